// File: rtl/nonce_search_pkg.sv
// Shared types, widths and byte-order helpers for the nonce search controller.
package nonce_search_pkg;

  localparam int HEADER_W = 640;
  localparam int PREFIX_W = 608;
  localparam int HASH_W   = 256;
  localparam int NONCE_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    REPORT
  } state_t;

  // Reverse the four bytes of a 32-bit word (header stores the nonce little-endian).
  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Reverse the 32 bytes of a hash: SHA byte order to unsigned-integer order.
  function automatic logic [HASH_W-1:0] bswap256(input logic [HASH_W-1:0] x);
    logic [HASH_W-1:0] r;
    r = '0;
    for (int i = 0; i < HASH_W / 8; i++) begin
      r[8*i +: 8] = x[HASH_W-8-8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/target_compare.sv
// Combinational difficulty check: byte-reversed hash compared (unsigned, <=) to a target.
module target_compare
  import nonce_search_pkg::*;
(
  input  logic [HASH_W-1:0] hash,
  input  logic [HASH_W-1:0] target,
  output logic              hit
);

  logic [HASH_W-1:0] hash_le;

  // The hash arrives with byte 0 in the top byte; the integer value has byte 31 on top.
  genvar gi;
  generate
    for (gi = 0; gi < HASH_W / 8; gi++) begin : g_rev
      assign hash_le[8*gi +: 8] = hash[HASH_W-8-8*gi +: 8];
    end
  endgenerate

  // A hash wins when its integer value does not exceed the target.
  assign hit = (hash_le <= target);

endmodule

// File: rtl/nonce_search_ctrl.sv
// Mining job controller: walks a nonce range, one double-SHA256 at a time,
// and reports every nonce whose hash meets the target.
module nonce_search_ctrl
  import nonce_search_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [PREFIX_W-1:0] job_prefix,
  input  logic [HASH_W-1:0]   job_target,
  input  logic [NONCE_W-1:0]  job_nonce_start,
  input  logic [NONCE_W-1:0]  job_nonce_end,
  input  logic                abort,
  output logic                hash_start,
  output logic [HEADER_W-1:0] hash_header,
  input  logic [HASH_W-1:0]   hash_in,
  input  logic                hash_done,
  output logic                found_valid,
  input  logic                found_ready,
  output logic [NONCE_W-1:0]  found_nonce,
  output logic [HASH_W-1:0]   found_hash,
  output logic                busy,
  output logic                exhausted,
  output logic                aborted,
  output logic                timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state_reg;
  logic [PREFIX_W-1:0] prefix_reg;
  logic [HASH_W-1:0]   target_reg;
  logic [NONCE_W-1:0]  end_reg;
  logic [NONCE_W-1:0]  nonce_reg;
  logic [CNT_W-1:0]    wait_cnt_reg;
  logic [HASH_W-1:0]   hash_reg;
  logic                done_q_reg;

  logic                done_edge;
  logic                hit;
  logic                do_advance;
  logic [NONCE_W-1:0]  nonce_next;

  // Captured hash against the latched target; result is used only in CHECK.
  target_compare u_target_compare (
    .hash   (hash_reg),
    .target (target_reg),
    .hit    (hit)
  );

  // Rising edge of the hasher's done; a level left high cannot re-trigger.
  assign done_edge  = hash_done & ~done_q_reg;
  assign nonce_next = nonce_reg + 1'b1;

  // Move on to the next nonce after a miss, or after a reported hit is consumed.
  assign do_advance = ((state_reg == CHECK) && !hit) ||
                      ((state_reg == REPORT) && found_ready);

  // Job FSM with all outputs registered; abort overrides every other transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      prefix_reg   <= '0;
      target_reg   <= '0;
      end_reg      <= '0;
      nonce_reg    <= '0;
      wait_cnt_reg <= '0;
      hash_reg     <= '0;
      done_q_reg   <= 1'b0;
      job_ready    <= 1'b1;
      hash_start   <= 1'b0;
      hash_header  <= '0;
      found_valid  <= 1'b0;
      found_nonce  <= '0;
      found_hash   <= '0;
      busy         <= 1'b0;
      exhausted    <= 1'b0;
      aborted      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      hash_start <= 1'b0;
      exhausted  <= 1'b0;
      aborted    <= 1'b0;
      timeout    <= 1'b0;
      done_q_reg <= hash_done;

      if (abort && (state_reg != IDLE)) begin
        state_reg   <= IDLE;
        job_ready   <= 1'b1;
        busy        <= 1'b0;
        aborted     <= 1'b1;
        found_valid <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (job_valid) begin
              prefix_reg  <= job_prefix;
              target_reg  <= job_target;
              end_reg     <= job_nonce_end;
              nonce_reg   <= job_nonce_start;
              hash_header <= {job_prefix, bswap32(job_nonce_start)};
              hash_start  <= 1'b1;
              job_ready   <= 1'b0;
              busy        <= 1'b1;
              state_reg   <= ISSUE;
            end
          end
          ISSUE: begin
            wait_cnt_reg <= '0;
            state_reg    <= WAIT;
          end
          WAIT: begin
            if (done_edge) begin
              hash_reg  <= hash_in;
              state_reg <= CHECK;
            end else if (wait_cnt_reg == TIMEOUT_LAST) begin
              timeout   <= 1'b1;
              job_ready <= 1'b1;
              busy      <= 1'b0;
              state_reg <= IDLE;
            end else begin
              wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
          end
          CHECK: begin
            if (hit) begin
              found_valid <= 1'b1;
              found_nonce <= nonce_reg;
              found_hash  <= hash_reg;
              state_reg   <= REPORT;
            end
          end
          REPORT: begin
            if (found_ready) begin
              found_valid <= 1'b0;
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase

        if (do_advance) begin
          if (nonce_reg == end_reg) begin
            exhausted <= 1'b1;
            job_ready <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            nonce_reg   <= nonce_next;
            hash_header <= {prefix_reg, bswap32(nonce_next)};
            hash_start  <= 1'b1;
            state_reg   <= ISSUE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Directed bench for nonce_search_ctrl with a fixed-latency stub hasher.
module tb_nonce_search_ctrl;

  localparam logic [255:0] HIT_HASH = {16'h3412, 240'h0};
  localparam logic [255:0] ALL_ONES = {256{1'b1}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [607:0] job_prefix = '0;
  logic [255:0] job_target = '0;
  logic [31:0]  job_nonce_start = '0;
  logic [31:0]  job_nonce_end = '0;
  logic         abort = 1'b0;
  logic         hash_start;
  logic [639:0] hash_header;
  logic [255:0] hash_in;
  logic         hash_done;
  logic         found_valid;
  logic         found_ready = 1'b0;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic         busy;
  logic         exhausted;
  logic         aborted;
  logic         timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Stub hasher state
  logic         stub_done = 1'b0;
  logic [255:0] stub_hash = ALL_ONES;
  logic         man_done = 1'b0;
  logic         man_sel = 1'b0;
  logic [255:0] man_hash = '0;
  bit           stub_silent = 1'b0;
  bit           stub_hit_en = 1'b0;
  logic [31:0]  stub_hit_nonce = '0;
  logic [31:0]  stub_nonce = '0;
  int           stub_cnt = 0;

  assign hash_done = stub_done | man_done;
  assign hash_in   = man_sel ? man_hash : stub_hash;

  nonce_search_ctrl #(
    .TIMEOUT_CYCLES (4096),
    .CNT_W          (13)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_prefix      (job_prefix),
    .job_target      (job_target),
    .job_nonce_start (job_nonce_start),
    .job_nonce_end   (job_nonce_end),
    .abort           (abort),
    .hash_start      (hash_start),
    .hash_header     (hash_header),
    .hash_in         (hash_in),
    .hash_done       (hash_done),
    .found_valid     (found_valid),
    .found_ready     (found_ready),
    .found_nonce     (found_nonce),
    .found_hash      (found_hash),
    .busy            (busy),
    .exhausted       (exhausted),
    .aborted         (aborted),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  // Stub hasher: done pulses one cycle, ten cycles after start; hash depends on nonce.
  always @(negedge clk) begin
    stub_done = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0) begin
        stub_done = 1'b1;
        stub_hash = (stub_hit_en && (stub_nonce == stub_hit_nonce)) ? HIT_HASH : ALL_ONES;
      end
    end
    if (hash_start && !stub_silent) begin
      stub_cnt   = 10;
      stub_nonce = {hash_header[7:0], hash_header[15:8], hash_header[23:16], hash_header[31:24]};
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]      start;
    logic [31:0]      last;
    logic [255:0]     target;
    bit               hit_en;
    logic [31:0]      hit_nonce;
    int               hold;
    int               n;
    logic [3:0][31:0] hdr;
    int               founds;
    logic [31:0]      fnonce;
    logic [255:0]     fhash;
  } job_t;

  job_t tbl [6];

  // Offer one job, serve results, and compare headers/results once the range is exhausted.
  task automatic run_job(input int idx, input job_t r);
    int               starts = 0;
    int               founds = 0;
    int               hold = 0;
    bit               done = 1'b0;
    bit               stable_ok = 1'b1;
    bit               odd = 1'b0;
    logic [3:0][31:0] seen = '0;
    logic [31:0]      last_fn = '0;
    logic [255:0]     last_fh = '0;
    logic [607:0]     pfx;
    pfx             = {19{r.start ^ 32'h5A5A_0F0F}};
    stub_silent     = 1'b0;
    stub_hit_en     = r.hit_en;
    stub_hit_nonce  = r.hit_nonce;
    job_prefix      = pfx;
    job_target      = r.target;
    job_nonce_start = r.start;
    job_nonce_end   = r.last;
    job_valid       = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      found_ready = 1'b0;
      if (hash_start) begin
        if (starts < 4) seen[starts] = hash_header[31:0];
        if (hash_header[639:32] !== pfx) odd = 1'b1;
        starts++;
      end
      if (found_valid) begin
        if (hold < r.hold) begin
          hold++;
          if (found_nonce !== r.fnonce || found_hash !== r.fhash) stable_ok = 1'b0;
        end else begin
          found_ready = 1'b1;
          founds++;
          last_fn = found_nonce;
          last_fh = found_hash;
          hold    = 0;
        end
      end
      if (aborted || timeout) odd = 1'b1;
      if (exhausted) done = 1'b1;
      else @(negedge clk);
    end
    found_ready = 1'b0;
    check($sformatf("job%0d exhausted", idx), 256'(done), 256'(1));
    check($sformatf("job%0d start count", idx), 256'(starts), 256'(r.n));
    for (int i = 0; i < r.n && i < 4; i++) begin
      check($sformatf("job%0d header nonce %0d", idx, i), 256'(seen[i]), 256'(r.hdr[i]));
    end
    check($sformatf("job%0d prefix/stray pulses", idx), 256'(odd), 256'(0));
    check($sformatf("job%0d found count", idx), 256'(founds), 256'(r.founds));
    if (r.founds > 0) begin
      check($sformatf("job%0d found_nonce", idx), 256'(last_fn), 256'(r.fnonce));
      check($sformatf("job%0d found_hash", idx), last_fh, r.fhash);
    end
    if (r.hold > 0) check($sformatf("job%0d held result stable", idx), 256'(stable_ok), 256'(1));
    check($sformatf("job%0d job_ready with exhausted", idx), 256'(job_ready), 256'(1));
    @(negedge clk);
    check($sformatf("job%0d exhausted one cycle", idx), 256'({exhausted, found_valid, busy}), 256'(0));
    $display("[TB] job %0d start=%h end=%h starts=%0d founds=%0d", idx, r.start, r.last, starts, founds);
  endtask

  initial begin
    int  k;
    bit  activity;

    tbl[0] = '{start: 32'd5, last: 32'd7, target: 256'h0, hit_en: 1'b0, hit_nonce: 32'd0,
               hold: 0, n: 3, hdr: {32'h0, 32'h0700_0000, 32'h0600_0000, 32'h0500_0000},
               founds: 0, fnonce: 32'd0, fhash: 256'h0};
    tbl[1] = '{start: 32'd5, last: 32'd7, target: 256'h1234, hit_en: 1'b1, hit_nonce: 32'd6,
               hold: 20, n: 3, hdr: {32'h0, 32'h0700_0000, 32'h0600_0000, 32'h0500_0000},
               founds: 1, fnonce: 32'd6, fhash: HIT_HASH};
    tbl[2] = '{start: 32'hFFFF_FFFE, last: 32'd1, target: 256'h0, hit_en: 1'b0, hit_nonce: 32'd0,
               hold: 0, n: 4, hdr: {32'h0100_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFEFF_FFFF},
               founds: 0, fnonce: 32'd0, fhash: 256'h0};
    tbl[3] = '{start: 32'd9, last: 32'd9, target: 256'h0, hit_en: 1'b0, hit_nonce: 32'd0,
               hold: 0, n: 1, hdr: {32'h0, 32'h0, 32'h0, 32'h0900_0000},
               founds: 0, fnonce: 32'd0, fhash: 256'h0};
    tbl[4] = '{start: 32'd0, last: 32'd2, target: ALL_ONES, hit_en: 1'b0, hit_nonce: 32'd0,
               hold: 0, n: 3, hdr: {32'h0, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000},
               founds: 3, fnonce: 32'd2, fhash: ALL_ONES};
    tbl[5] = '{start: 32'd5, last: 32'd7, target: 256'h1233, hit_en: 1'b1, hit_nonce: 32'd6,
               hold: 0, n: 3, hdr: {32'h0, 32'h0700_0000, 32'h0600_0000, 32'h0500_0000},
               founds: 0, fnonce: 32'd0, fhash: 256'h0};

    // Asynchronous reset before any clock edge
    #2 rst = 1'b0;
    #1;
    check("reset job_ready", 256'(job_ready), 256'(1));
    check("reset flags", 256'({busy, hash_start, found_valid, exhausted, aborted, timeout}), 256'(0));
    check("reset header", 256'(hash_header[255:0]), 256'(0));
    check("reset found", found_hash | 256'(found_nonce), 256'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_job(i, tbl[i]);

    // Hasher never answers: timeout 4096 cycles after WAIT is entered
    stub_silent     = 1'b1;
    job_nonce_start = 32'd20;
    job_nonce_end   = 32'd20;
    job_valid       = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    check("timeout job issued", 256'(hash_start), 256'(1));
    k = 0;
    while (!timeout && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("timeout latency", 256'(k), 256'(4097));
    check("timeout job_ready", 256'({job_ready, busy}), 256'(2'b10));
    @(negedge clk);
    check("timeout one cycle", 256'(timeout), 256'(0));
    $display("[TB] timeout job: timeout seen %0d cycles after issue", k);

    // Abort coincident with a winning done edge
    job_target      = ALL_ONES;
    job_nonce_start = 32'd30;
    job_nonce_end   = 32'd30;
    job_valid       = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    repeat (3) @(negedge clk);
    man_sel  = 1'b1;
    man_hash = '0;
    man_done = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    check("abort+done pulse", 256'({aborted, job_ready, busy, found_valid}), 256'(4'b1100));
    abort    = 1'b0;
    man_done = 1'b0;
    activity = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (found_valid || aborted || busy) activity = 1'b1;
    end
    check("abort+done no result", 256'(activity), 256'(0));
    man_sel = 1'b0;
    $display("[TB] abort with coincident hit done");

    // Abort held in IDLE does not block acceptance; it kills the job once busy
    abort           = 1'b1;
    job_nonce_start = 32'd50;
    job_nonce_end   = 32'd60;
    job_valid       = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    check("abort in idle accepted", 256'({busy, hash_start, aborted}), 256'(3'b110));
    @(negedge clk);
    check("abort in issue", 256'({aborted, job_ready, busy}), 256'(3'b110));
    abort = 1'b0;
    @(negedge clk);
    check("abort one cycle", 256'(aborted), 256'(0));
    $display("[TB] abort held across IDLE");

    // Asynchronous reset mid-WAIT, then a stray done
    stub_silent     = 1'b0;
    stub_hit_en     = 1'b0;
    job_target      = ALL_ONES;
    job_nonce_start = 32'd40;
    job_nonce_end   = 32'd45;
    job_valid       = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset busy", 256'(busy), 256'(1));
    #2 rst = 1'b0;
    #1;
    check("async reset outputs", 256'({job_ready, busy, hash_start, found_valid}), 256'(4'b1000));
    check("async reset header", 256'(hash_header[639:384]), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    activity = 1'b0;
    for (int c = 0; c < 30; c++) begin
      man_done = (c == 20);
      @(negedge clk);
      if (hash_start || busy || found_valid || exhausted || aborted || timeout || !job_ready)
        activity = 1'b1;
    end
    man_done = 1'b0;
    check("stray done ignored", 256'(activity), 256'(0));
    $display("[TB] async reset mid-WAIT");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
